// File: rtl/rv32i_types.sv
// Shared RV32I types used by the memory-access stage.
// Holds the opcode encoding, the control word carried down the pipeline,
// the load/store funct3 encodings and the MA-stage FSM state type.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } ma_state_t;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic        load_regfile;
    logic [4:0]  rd;
  } rv32i_control_word;

endpackage

// File: rtl/memory_access_stage_load_align.sv
// Load alignment for the MA stage.
// Shifts the 32-bit memory word down by the byte offset of the access and
// sign- or zero-extends the selected byte/halfword according to funct3.
// Ports:
//   rdata_i   32-bit word returned by data memory
//   offset_i  alu_out[1:0], byte offset within the word
//   funct3_i  load funct3 (lb/lh/lw/lbu/lhu)
//   data_o    aligned, extended load result
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (load_funct3_t'(funct3_i))
      lb:      data_o = {{24{shifted[7]}}, shifted[7:0]};
      lbu:     data_o = {24'h0, shifted[7:0]};
      lh:      data_o = {{16{shifted[15]}}, shifted[15:0]};
      lhu:     data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MA pipeline stage.
// Takes the EX/MA register contents, issues a single read or write on the
// data-memory handshake, stalls upstream until the access completes, and
// registers the result into the MA/WB register.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ctrl_word_in .. br_en_in  EX/MA register contents
//   IF_stall                  fetch-side freeze of the whole pipeline
//   data_mem_*                data-memory request / response handshake
//   MA_stall                  upstream freeze request
//   *_out                     MA/WB register copies
//   stall_cycles              saturating count of cycles with MA_stall high
module memory_access_stage
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_control_word ctrl_word_in,
  input  logic [31:0]       instruction_in,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       alu_out_in,
  input  logic [31:0]       rs2_in,
  input  logic              br_en_in,
  input  logic [3:0]        mem_byte_enable_in,
  input  logic              IF_stall,
  input  logic              data_mem_resp,
  input  logic [31:0]       data_mem_rdata,
  output logic              data_mem_read,
  output logic              data_mem_write,
  output logic [31:0]       data_mem_address,
  output logic [31:0]       data_mem_wdata,
  output logic [3:0]        data_mem_mbe,
  output logic              MA_stall,
  output rv32i_control_word ctrl_word_out,
  output logic [31:0]       instruction_out,
  output logic [31:0]       PC_out,
  output logic [31:0]       alu_out_out,
  output logic [31:0]       mem_rdata_out,
  output logic              br_en_out,
  output logic [CNT_W-1:0]  stall_cycles
);

  ma_state_t         state_q, state_d;
  logic              is_load, is_store, memop, advance;
  logic              stall_d, read_d, write_d;
  logic [31:0]       load_word, rdata_d;
  logic [31:0]       hold_q;
  rv32i_control_word ctrl_q;
  logic [31:0]       instr_q, pc_q, alu_q, rdata_q;
  logic              br_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign is_load  = (ctrl_word_in.opcode == op_load);
  assign is_store = (ctrl_word_in.opcode == op_store);
  assign memop    = is_load || is_store;

  load_align u_load_align (
    .rdata_i  (data_mem_rdata),
    .offset_i (alu_out_in[1:0]),
    .funct3_i (instruction_in[14:12]),
    .data_o   (load_word)
  );

  // The request is only raised from BUSY, so IDLE spends one cycle stalling
  // before the access; HOLD keeps the completed load while fetch is frozen.
  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    read_d  = 1'b0;
    write_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          state_d = BUSY;
          stall_d = 1'b1;
        end
      end
      BUSY: begin
        read_d  = is_load;
        write_d = is_store;
        stall_d = !data_mem_resp;
        if (data_mem_resp) state_d = IF_stall ? HOLD : IDLE;
      end
      HOLD: begin
        if (!IF_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Requests and the stall must drop the instant reset is asserted.
    if (rst) begin
      stall_d = 1'b0;
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end

  assign MA_stall       = stall_d;
  assign data_mem_read  = read_d;
  assign data_mem_write = write_d;
  assign advance        = !stall_d && !IF_stall;

  assign data_mem_address = {alu_out_in[31:2], 2'b00};
  assign data_mem_wdata   = rs2_in << {alu_out_in[1:0], 3'b000};
  assign data_mem_mbe     = is_store ? mem_byte_enable_in : 4'b1111;

  // A load leaving from HOLD uses the captured word; memory may have moved on.
  always_comb begin
    rdata_d = '0;
    if (is_load) rdata_d = (state_q == HOLD) ? hold_q : load_word;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == BUSY) && data_mem_resp && IF_stall) hold_q <= load_word;
    end
  end

  // MA/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      br_q    <= 1'b0;
    end else if (advance) begin
      ctrl_q  <= ctrl_word_in;
      instr_q <= instruction_in;
      pc_q    <= PC_in;
      alu_q   <= alu_out_in;
      rdata_q <= rdata_d;
      br_q    <= br_en_in;
    end
  end

  assign ctrl_word_out   = ctrl_q;
  assign instruction_out = instr_q;
  assign PC_out          = pc_q;
  assign alu_out_out     = alu_q;
  assign mem_rdata_out   = rdata_q;
  assign br_en_out       = br_q;
  assign stall_cycles    = cnt_q;

endmodule
